cic_dec_ctrl: RTL and testbench

Sequencing controller for the 3-stage CIC decimator datapath.
- Programs the decimation ratio R and generates the comb-section sample strobe (cic_sample) and the decimated clock (clk2).
- Clears the integrators while idle and discards comb outputs during pipeline warm-up.
- Buffers decimated samples in a small FIFO with a valid/ready handshake toward downstream logic.

---
 rtl/cic_dec_ctrl_if.sv | 21 ++
 rtl/cic_dec_ctrl.sv | 149 ++++++++++++++
 tb/tb_cic_dec_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cic_dec_ctrl_if.sv
// cic_dec_ctrl_if: decimated sample stream
// head sample plus valid/ready handshake
interface cic_dec_ctrl_if #(
    parameter int DW = 10
);
    logic [DW-1:0] y_out;
    logic          y_valid;
    logic          y_ready;

    modport master (
        output y_out,
        output y_valid,
        input  y_ready
    );

    modport slave (
        input  y_out,
        input  y_valid,
        output y_ready
    );
endinterface

// File: rtl/cic_dec_ctrl.sv
// cic_dec_ctrl: CIC decimator sequencer
// ratio, strobes, warm-up discard, output FIFO
module cic_dec_ctrl #(
    parameter int RW    = 6,
    parameter int DEF_R = 32,
    parameter int WARM  = 3,
    parameter int DW    = 10,
    parameter int FD    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          cfg_we,
    input  logic [RW-1:0] cfg_r,
    input  logic [DW-1:0] cic_y,
    output logic          cic_clear,
    output logic          cic_sample,
    output logic          clk2,
    output logic          ovf,
    output logic          busy,
    output logic [1:0]    state_out,
    cic_dec_ctrl_if.master yo
);
    localparam int AW = $clog2(FD);
    localparam int WW = $clog2(WARM + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WARMUP = 2'b01,
        RUN    = 2'b10,
        DRAIN  = 2'b11
    } state_t;

    state_t        state;
    logic [RW-1:0] r_reg;
    logic [RW-1:0] cnt;
    logic [WW-1:0] warm;
    logic          cap;

    logic [DW-1:0] mem [FD];
    logic [AW:0]   wp;
    logic [AW:0]   rp;
    logic [AW:0]   fcnt;
    logic [AW:0]   nxt_cnt;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          drop;

    assign state_out = state;

    // FIFO status and push/pop/drop decisions
    always_comb begin
        fcnt     = wp - rp;
        empty    = (wp == rp);
        full     = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
        pop      = !empty && yo.y_ready;
        push_req = cap && (state == RUN);
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        nxt_cnt  = fcnt + (AW+1)'(push) - (AW+1)'(pop);
    end

    // sequencing FSM: ratio, phase counter, strobes, warm-up
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            r_reg      <= RW'(DEF_R);
            cnt        <= '0;
            warm       <= '0;
            cap        <= 1'b0;
            cic_sample <= 1'b0;
            clk2       <= 1'b0;
            cic_clear  <= 1'b1;
            busy       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            cap        <= cic_sample;
            cic_sample <= 1'b0;
            clk2       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_we)
                        r_reg <= (cfg_r < RW'(2)) ? RW'(2) : cfg_r;
                    if (en) begin
                        state     <= WARMUP;
                        cnt       <= '0;
                        warm      <= '0;
                        ovf       <= 1'b0;
                        cic_clear <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                WARMUP, RUN: begin
                    if (!en) begin
                        state <= DRAIN;
                    end else begin
                        if (cnt == r_reg - RW'(1)) begin
                            cnt        <= '0;
                            cic_sample <= 1'b1;
                            clk2       <= 1'b1;
                        end else begin
                            cnt <= cnt + RW'(1);
                        end
                        if (state == WARMUP && cap) begin
                            warm <= warm + WW'(1);
                            if (warm == WW'(WARM - 1))
                                state <= RUN;
                        end
                    end
                    if (drop)
                        ovf <= 1'b1;
                end
                DRAIN: begin
                    if (empty) begin
                        state     <= IDLE;
                        cic_clear <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
            endcase
        end
    end

    // output FIFO with registered head and valid
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp         <= '0;
            rp         <= '0;
            yo.y_out   <= '0;
            yo.y_valid <= 1'b0;
        end else begin
            if (push) begin
                mem[wp[AW-1:0]] <= cic_y;
                wp <= wp + (AW+1)'(1);
            end
            if (pop)
                rp <= rp + (AW+1)'(1);
            if (pop && fcnt > (AW+1)'(1))
                yo.y_out <= mem[rp[AW-1:0] + AW'(1)];
            else if (push && (empty || pop))
                yo.y_out <= cic_y;
            yo.y_valid <= (nxt_cnt != '0);
        end
    end
endmodule

// File: tb/tb_cic_dec_ctrl.sv
// tb_cic_dec_ctrl: randomized bench for cic_dec_ctrl
// per-cycle check against an arithmetic/queue model
module tb_cic_dec_ctrl;
    localparam int RW    = 6;
    localparam int DEF_R = 32;
    localparam int WARM  = 3;
    localparam int DW    = 10;
    localparam int FD    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          cfg_we = 1'b0;
    logic [RW-1:0] cfg_r = '0;
    logic [DW-1:0] cic_y = '0;
    logic          rdy = 1'b0;
    logic          cic_clear;
    logic          cic_sample;
    logic          clk2;
    logic          ovf;
    logic          busy;
    logic [1:0]    state_out;

    cic_dec_ctrl_if #(.DW(DW)) yo ();
    assign yo.y_ready = rdy;

    cic_dec_ctrl #(
        .RW(RW), .DEF_R(DEF_R), .WARM(WARM), .DW(DW), .FD(FD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .cfg_we(cfg_we),
        .cfg_r(cfg_r),
        .cic_y(cic_y),
        .cic_clear(cic_clear),
        .cic_sample(cic_sample),
        .clk2(clk2),
        .ovf(ovf),
        .busy(busy),
        .state_out(state_out),
        .yo(yo.master)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_on = 0;
    bit rnd_rdy = 0;

    // model: state in output encoding, ratio, entry cycle,
    // warm-up capture count, sample queue, pulse history
    int            cyc = 0;
    int            ms = 0;
    int            mr = DEF_R;
    int            te = 0;
    int            mwarm = 0;
    bit            movf = 0;
    bit            mp0 = 0;
    bit            mp1 = 0;
    logic [DW-1:0] my = '0;
    logic [DW-1:0] q[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic edge_model();
        bit cap;
        bit pop;
        bit full;
        bit push;
        int ns;
        int n;
        cyc++;
        if (!reset) begin
            ms = 0; mr = DEF_R; mwarm = 0; movf = 0;
            my = '0; mp0 = 0; mp1 = 0; q.delete();
            return;
        end
        cap  = mp0;
        pop  = (q.size() > 0) && rdy;
        full = (q.size() == FD);
        push = 0;
        ns   = ms;
        case (ms)
            0: begin
                if (cfg_we) mr = (int'(cfg_r) < 2) ? 2 : int'(cfg_r);
                if (en) begin
                    ns = 1; te = cyc; mwarm = 0; movf = 0;
                end
            end
            1, 2: begin
                if (cap) begin
                    if (ms == 1) begin
                        mwarm++;
                        if (mwarm == WARM) ns = 2;
                    end else begin
                        push = 1;
                    end
                end
                if (!en) ns = 3;
            end
            default: if (q.size() == 0) ns = 0;
        endcase
        if (pop) void'(q.pop_front());
        if (push) begin
            if (full && !pop) movf = 1;
            else q.push_back(cic_y);
        end
        if (q.size() > 0) my = q[0];
        ms  = ns;
        mp0 = mp1;
        n   = cyc - te;
        mp1 = (ms == 1 || ms == 2) && n > 0 && (n % mr) == 0;
    endtask

    task automatic check_all();
        chk("state", 32'(state_out), 32'(ms));
        chk("busy", 32'(busy), 32'(ms != 0));
        chk("cic_clear", 32'(cic_clear), 32'(ms == 0));
        chk("cic_sample", 32'(cic_sample), 32'(mp1));
        chk("clk2", 32'(clk2), 32'(mp1));
        chk("y_valid", 32'(yo.y_valid), 32'(q.size() > 0));
        chk("y_out", 32'(yo.y_out), 32'(my));
        chk("ovf", 32'(ovf), 32'(movf));
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            edge_model();
            #1;
            if (chk_on) check_all();
            cic_y = DW'($urandom);
            if (rnd_rdy) rdy = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_idle(int lim);
        int k = 0;
        while (state_out !== 2'b00 && k < lim) begin
            step(1);
            k++;
        end
        chk("drain_to_idle", 32'(state_out), 32'd0);
    endtask

    task automatic start(int r);
        cfg_we = 1'b1;
        cfg_r  = RW'(r);
        en     = 1'b1;
        step(1);
        cfg_we = 1'b0;
    endtask

    initial begin
        step(2);
        chk_on = 1;
        step(1);
        reset = 1'b1;

        // defaults, no readiness: first push lands at cycle 130
        rdy = 1'b0;
        en  = 1'b1;
        step(140);
        en  = 1'b0;
        rdy = 1'b1;
        wait_idle(50);

        // ratio 8 with random ready, ignored write during run
        start(8);
        rnd_rdy = 1;
        step(60);
        cfg_we = 1'b1;
        cfg_r  = RW'(5);
        step(1);
        cfg_we = 1'b0;
        step(60);
        en = 1'b0;
        rnd_rdy = 0;
        rdy = 1'b1;
        wait_idle(50);

        // ratio 1 clamps to 2
        start(1);
        rnd_rdy = 1;
        step(40);
        en = 1'b0;
        rnd_rdy = 0;
        rdy = 1'b1;
        wait_idle(50);

        // ratio 4: fill, overflow, then drain in order
        start(4);
        rdy = 1'b0;
        step(60);
        rdy = 1'b1;
        step(20);
        en = 1'b0;
        wait_idle(50);

        // full FIFO with pop aligned to each push: no ovf
        start(4);
        rdy = 1'b0;
        for (int k = 0; k < 100 && q.size() < FD; k++) step(1);
        for (int k = 0; k < 16; k++) begin
            rdy = mp0 && (q.size() == FD);
            step(1);
        end
        rdy = 1'b0;
        step(10);

        // drain with en pulse ignored
        en = 1'b0;
        step(3);
        en = 1'b1;
        step(1);
        en = 1'b0;
        step(2);
        rdy = 1'b1;
        wait_idle(50);

        // mid-run reset with FIFO non-empty
        start(4);
        rdy = 1'b0;
        step(60);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        en = 1'b0;
        step(3);

        // default ratio restored after reset
        en = 1'b1;
        step(70);
        en = 1'b0;
        rdy = 1'b1;
        wait_idle(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
